// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, tracked keycodes, FSM state types
// and small byte-classification helpers used by the receiver and decoder.
package ps2_pkg;

    // Protocol prefix bytes
    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;

    // Movement / orientation keycodes shared with the pose tracker
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_SHIFT = 8'h12;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_IN    = 8'h15;
    localparam logic [7:0] KEY_OUT   = 8'h24;

    typedef enum logic [1:0] {
        FR_IDLE   = 2'd0,
        FR_DATA   = 2'd1,
        FR_PARITY = 2'd2,
        FR_STOP   = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        PR_BASE    = 2'd0,
        PR_EXT     = 2'd1,
        PR_BRK     = 2'd2,
        PR_EXT_BRK = 2'd3
    } proto_state_t;

    // Bytes the keyboard sends that never represent a key press
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default:                                          is_ignored = 1'b0;
        endcase
    endfunction

    // Odd parity across data and parity bit: total count of ones must be odd
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        odd_parity_ok = ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the device lines, detects falling clock
// edges, shifts in start/data/parity/stop and aborts stalled frames.
// byte_valid / byte_err are single-cycle strobes on the decision cycle so the
// top level can register its outputs one cycle after the stop edge.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] dat_sync_r;
    logic                   clk_prev_r;
    frame_state_t           state_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   parity_r;
    logic [CW-1:0]          count_r;

    logic fall_s;
    logic dat_s;
    logic timeout_s;

    assign fall_s    = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    assign dat_s     = dat_sync_r[SYNC_STAGES-1];
    assign timeout_s = ~fall_s & (count_r == TO_LAST);
    assign rx_byte   = shift_r;

    // Synchronisers, edge history and the frame state machine with timeout
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_sync_r <= {SYNC_STAGES{1'b0}};
            dat_sync_r <= {SYNC_STAGES{1'b0}};
            clk_prev_r <= 1'b0;
            state_r    <= FR_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            count_r    <= {CW{1'b0}};
        end else begin
            clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], PS2_DAT};
            clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
            case (state_r)
                FR_IDLE: begin
                    count_r <= {CW{1'b0}};
                    if (fall_s && !dat_s) begin
                        state_r   <= FR_DATA;
                        bit_cnt_r <= 3'd0;
                    end else begin
                        state_r   <= FR_IDLE;
                    end
                end
                FR_DATA, FR_PARITY, FR_STOP: begin
                    if (fall_s) begin
                        count_r <= {CW{1'b0}};
                        if (state_r == FR_DATA) begin
                            shift_r   <= {dat_s, shift_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= FR_PARITY;
                            end else begin
                                state_r <= FR_DATA;
                            end
                        end else if (state_r == FR_PARITY) begin
                            parity_r <= dat_s;
                            state_r  <= FR_STOP;
                        end else begin
                            state_r  <= FR_IDLE;
                        end
                    end else if (timeout_s) begin
                        count_r <= {CW{1'b0}};
                        state_r <= FR_IDLE;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= FR_IDLE;
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Decision strobes: good byte at the stop edge, or any framing failure
    always_comb begin
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (state_r)
            FR_IDLE: begin
                if (fall_s && dat_s) begin
                    byte_err = 1'b1;
                end else begin
                    byte_err = 1'b0;
                end
            end
            FR_STOP: begin
                if (fall_s) begin
                    if (dat_s && odd_parity_ok(shift_r, parity_r)) begin
                        byte_valid = 1'b1;
                    end else begin
                        byte_err = 1'b1;
                    end
                end else if (timeout_s) begin
                    byte_err = 1'b1;
                end else begin
                    byte_err = 1'b0;
                end
            end
            FR_DATA, FR_PARITY: begin
                if (timeout_s) begin
                    byte_err = 1'b1;
                end else begin
                    byte_err = 1'b0;
                end
            end
            default: begin
                byte_valid = 1'b0;
                byte_err   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ps2_keycode_tracker.sv
// PS/2 keyboard front end for the pose tracker: turns make/break/extended
// byte sequences into a held-level keycode (0x00 when nothing tracked is down).
module ps2_keycode_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       extended,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0]   rx_byte_s;
    logic         byte_valid_s;
    logic         byte_err_s;
    proto_state_t proto_r;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .rx_byte    (rx_byte_s),
        .byte_valid (byte_valid_s),
        .byte_err   (byte_err_s)
    );

    // Prefix decoder and registered outputs; a framing error drops any prefix
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            proto_r    <= PR_BASE;
            keycode    <= 8'h00;
            extended   <= 1'b0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= byte_valid_s;
            frame_err  <= byte_err_s;
            if (byte_err_s) begin
                proto_r <= PR_BASE;
            end else if (byte_valid_s) begin
                scan_code <= rx_byte_s;
                case (proto_r)
                    PR_BASE: begin
                        if (rx_byte_s == PS2_E0) begin
                            proto_r <= PR_EXT;
                        end else if (rx_byte_s == PS2_F0) begin
                            proto_r <= PR_BRK;
                        end else if (is_ignored(rx_byte_s)) begin
                            proto_r <= PR_BASE;
                        end else begin
                            keycode  <= rx_byte_s;
                            extended <= 1'b0;
                            proto_r  <= PR_BASE;
                        end
                    end
                    PR_EXT: begin
                        if (rx_byte_s == PS2_F0) begin
                            proto_r <= PR_EXT_BRK;
                        end else if (is_ignored(rx_byte_s)) begin
                            proto_r <= PR_BASE;
                        end else begin
                            keycode  <= rx_byte_s;
                            extended <= 1'b1;
                            proto_r  <= PR_BASE;
                        end
                    end
                    PR_BRK: begin
                        if (rx_byte_s == keycode && !extended) begin
                            keycode <= 8'h00;
                        end else begin
                            keycode <= keycode;
                        end
                        proto_r <= PR_BASE;
                    end
                    PR_EXT_BRK: begin
                        if (rx_byte_s == keycode && extended) begin
                            keycode  <= 8'h00;
                            extended <= 1'b0;
                        end else begin
                            keycode  <= keycode;
                        end
                        proto_r <= PR_BASE;
                    end
                    default: begin
                        proto_r <= PR_BASE;
                    end
                endcase
            end else begin
                proto_r <= proto_r;
            end
        end
    end

endmodule

// File: doc/ps2_keycode_tracker.md
Name: ps2_keycode_tracker

Overview:
Upstream input stage for the pose tracker.
- Receives raw PS/2 keyboard frames.
- Decodes make/break/extended sequences.
- Presents an 8-bit keycode that stays stable while the key is held and is 0x00 when no tracked key is down.
- Output feeds the pose tracker's keycode input directly; the tracker's hold-to-repeat timing depends on this held-level semantics.

Parameters:
TIMEOUT_CYCLES, 100000, CLOCK_50 cycles of PS2_CLK inactivity (high) mid-frame before the frame is aborted (2 ms at 50 MHz).
SYNC_STAGES, 2, flip-flop stages synchronising PS2_CLK and PS2_DAT (min 2).

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
PS2_CLK  input  1  raw PS/2 clock from device, asynchronous
PS2_DAT  input  1  raw PS/2 data from device, asynchronous
keycode  output  8  currently held key scan code; 0x00 = none
extended  output  1  1 when held keycode arrived with E0 prefix
scan_code  output  8  last accepted raw byte
scan_valid  output  1  one-cycle pulse when scan_code updates
frame_err  output  1  one-cycle pulse on parity/start/stop error or timeout

Behaviour:
- Reset (reset=0, async): keycode=0x00, extended=0, scan_code=0x00, scan_valid=0, frame_err=0, both FSMs at idle/BASE, sync chains and counters cleared. Reset mid-frame discards the partial frame.
- Input sync: SYNC_STAGES flops per line. A falling edge is synchronised PS2_CLK going 1->0 on consecutive cycles; all data sampling happens on that cycle.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on falling edge, sample start; 0 -> DATA (bit count 0), 1 -> frame_err, stay IDLE.
  - DATA: 8 bits, LSB first; after the 8th -> PARITY.
  - PARITY: sample bit; odd parity over data+parity required.
  - STOP: sample stop; must be 1.
- Frame outcome:
  - Valid frame: scan_code and scan_valid registered on the cycle after the stop-bit edge (latency 1 cycle from stop edge).
  - Parity or stop failure: frame_err pulse at the same position instead, no scan_valid, protocol FSM forced to BASE.
- Timeout: in DATA/PARITY/STOP, a counter increments while no falling edge occurs and clears on each edge. At count == TIMEOUT_CYCLES-1: return to IDLE, pulse frame_err, protocol FSM -> BASE.
- Protocol FSM states: BASE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - BASE: E0 -> EXT; F0 -> BRK; ignored byte -> BASE; other byte b -> keycode=b, extended=0.
  - EXT: F0 -> EXT_BRK; ignored -> BASE; b -> keycode=b, extended=1, -> BASE.
  - BRK: b -> if b==keycode and extended==0 then keycode=0x00; else unchanged; -> BASE.
  - EXT_BRK: b -> if b==keycode and extended==1 then keycode=0x00, extended=0; -> BASE.
- Ignored bytes (no keycode change): 0x00, 0xAA, 0xE1, 0xEE, 0xFA, 0xFE, 0xFF.
- keycode and extended update on the same cycle scan_valid asserts.
- Typematic repeat of the held make code: keycode unchanged, no glitch through 0x00.
- New make while another key is held: keycode replaced (last-pressed wins).
- Break of a non-held key: ignored.
- scan_valid and frame_err are never asserted in the same cycle.
- Block never drives PS2_CLK/PS2_DAT (receive-only).

Decomposition:
- Package ps2_pkg holds:
  - Prefix constants E0, F0 and the ignored-byte list.
  - Movement/orientation keycode constants (W, A, S, D, SHIFT, SPACE, UP, DOWN, RIGHT, LEFT, IN, OUT), shared with the pose tracker.
  - Frame-FSM and protocol-FSM state enums.
- Sub-module ps2_rx_frame: synchronisers, edge detect, frame FSM, timeout. Outputs byte, byte_valid, byte_err.
- Top level: protocol FSM and output registers.

Test Plan:
1. Frame 0x1D (parity 1, stop 1) at 12.5 kHz -> scan_valid 1 pulse, scan_code=0x1D, keycode=0x1D, extended=0; two more 0x1D frames -> keycode stays 0x1D every cycle.
2. With 0x1D held, send F0 1C -> keycode stays 0x1D; send F0 1D -> keycode=0x00.
3. Send E0 75 -> keycode=0x75, extended=1; send F0 75 -> keycode stays 0x75; send E0 F0 75 -> keycode=0x00, extended=0.
4. Hold 0x23; send 0x1C frame with wrong parity -> frame_err 1 pulse, no scan_valid, keycode=0x23; then E0 frame with bad stop, then 0x74 -> keycode=0x74, extended=0 (prefix discarded).
5. Send start + 5 data bits, hold PS2_CLK high 100000 cycles -> frame_err pulse exactly at timeout; full 0x1B frame then decodes to keycode=0x1B.
6. Assert reset low mid-frame after 0x29 held -> all outputs 0 immediately (async); release, send 0x12 -> keycode=0x12; send AA and FA -> scan_valid pulses, keycode unchanged.
